alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the 3-bit combinational ALU.
- Adds arithmetic (ADD/ADC/SUB) and real flag generation.
- Shifts run iteratively, one bit per cycle; a valid/ready handshake sits on both sides.
- Sits between the operand/decode stage and the writeback stage; results and flags are registered.

Parameters:
- W, 8, datapath width in bits; legal range 4..32.
- OPW, 4, opcode width; fixed at 4. Any other value is a compile-time error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- opcode  in  OPW  operation select.
- a  in  W  operand 1.
- b  in  W  operand 2; for shifts, the unsigned shift amount.
- c_in  in  1  carry in; used by ADC only.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- y  out  W  result.
- c_out  out  1  carry / no-borrow / last bit shifted out.
- v  out  1  signed overflow.
- n  out  1  equals y[W-1].
- z  out  1  y == 0.
- busy  out  1  state is EXEC.

Behaviour:
- Opcodes: 0 ADD, 1 ADC, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT(a), 7 LSL, 8 LSR, 9 ASR, 10 MUL (optional). All other codes are illegal.
- States: IDLE, EXEC, DONE. Reset state is IDLE.
- Reset values: out_valid=0, y=0, c_out=v=n=z=0, busy=0.
- Reset asserted mid-EXEC or in DONE abandons the operation; no partial result is emitted.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept occurs on a rising edge where in_valid && in_ready. Operands are captured at that edge; later changes on a/b are ignored.
- Single-cycle ops (ADD, ADC, SUB, logic ops, NOT, illegal opcodes):
  - Accept at edge T goes straight to DONE.
  - out_valid=1 after edge T.
- Shifts:
  - Amount k = min(b, W).
  - k==0: handled as a single-cycle op; y=a, c_out=0.
  - k>0: EXEC for k cycles, one bit shifted per cycle. out_valid rises after edge T+k.
  - in_ready=0 throughout EXEC.
- DONE:
  - y and flags are held stable while out_valid && !out_ready.
  - out_ready=1 with no new accept: return to IDLE, out_valid falls.
  - Simultaneous out_ready and in_valid: the new op is accepted in the same edge (back-to-back, no bubble for single-cycle ops).
- Arithmetic:
  - ADD: {c_out,y} = a+b.
  - ADC: {c_out,y} = a+b+c_in.
  - SUB: y = a-b; c_out=1 iff a>=b unsigned.
  - v = signed overflow of the two's-complement result.
- Logic ops and NOT: c_out=0, v=0.
- Shifts:
  - c_out = last bit shifted out; v=0.
  - ASR fills with a[W-1]; LSL/LSR fill with 0.
- Illegal opcode: y=0, z=1, c_out=v=n=0; single-cycle.
- n and z are always derived from the final y.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - Opcode 10 = MUL: unsigned shift-add, exactly W EXEC cycles.
  - y = low W bits of the product; c_out=1 iff the high W bits are nonzero; v=0.
- Undefined: opcode 10 is illegal (behaviour as above) and the multiplier logic is absent.

Test Plan:
- ADD a=0x7F b=0x01 -> y=0x80, v=1, n=1, c_out=0, z=0; out_valid one cycle after accept.
- SUB a=0x05 b=0x05 -> y=0x00, z=1, c_out=1, v=0. Same op back-to-back with out_ready=1 -> accept every cycle, out_valid continuously 1.
- ASR a=0x90 b=3 -> y=0xF2, c_out=0, n=1; busy and in_ready=0 for 3 cycles, out_valid after the 3rd edge.
- LSL a=0x81 b=9 -> saturates to k=8; y=0x00, c_out=1, z=1; out_valid after 8 edges.
- Backpressure: ADD result held with out_ready=0 for 5 cycles -> y and flags stable, in_ready=0. Then rst_n=0 during a LSR b=6 at cycle 3 -> all outputs 0 and IDLE immediately (asynchronous), no out_valid afterwards.
- MUL a=0x10 b=0x11:
  - with ALU_SEQ_MUL_EN -> y=0x10, c_out=1 after 8 edges;
  - without -> y=0x00, z=1 after 1 edge.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with registered result/flags and valid/ready on both sides
//
// Optional multiplier: define ALU_SEQ_MUL_EN to enable opcode 10 (MUL, W-cycle shift-add).
// Without it opcode 10 behaves as an illegal opcode and no multiplier logic exists.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake (opcode, a, b, c_in captured on accept)
//   opcode            operation select (OPW = 4 bits)
//   a, b              operands; b is the unsigned shift amount for shifts
//   c_in              carry in, ADC only
//   out_valid/out_ready result handshake
//   y                 result
//   c_out, v, n, z    carry/no-borrow/last-shifted-out, signed overflow, negative, zero
//   busy              high while an iterative operation is executing
module alu_seq #(
    parameter int W   = 8,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] opcode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           c_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   y,
    output logic           c_out,
    output logic           v,
    output logic           n,
    output logic           z,
    output logic           busy
);

    if (OPW != 4) begin : g_opw_check
        $error("alu_seq: OPW must be 4");
    end
    if (W < 4 || W > 32) begin : g_w_check
        $error("alu_seq: W must be in 4..32");
    end

    localparam int CW = $clog2(W + 1);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_ADC = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB = OPW'(2);
    localparam logic [OPW-1:0] OP_AND = OPW'(3);
    localparam logic [OPW-1:0] OP_OR  = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR = OPW'(5);
    localparam logic [OPW-1:0] OP_NOT = OPW'(6);
    localparam logic [OPW-1:0] OP_LSL = OPW'(7);
    localparam logic [OPW-1:0] OP_LSR = OPW'(8);
    localparam logic [OPW-1:0] OP_ASR = OPW'(9);
`ifdef ALU_SEQ_MUL_EN
    localparam logic [OPW-1:0] OP_MUL = OPW'(10);
`endif

    localparam logic [W-1:0] W_AS_B = W'(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [OPW-1:0] op_q;
    logic [W-1:0]   sh_q;     // shift register; doubles as the multiplier/low product for MUL
    logic [CW-1:0]  cnt_q;    // remaining EXEC steps

    logic           accept;
    logic           is_shift_in;
    logic           is_mul_in;
    logic           multi_in;
    logic [CW-1:0]  k_amt;

    logic [W:0]     sum_add;
    logic [W:0]     diff_sub;
    logic [W-1:0]   s_y;
    logic           s_c;
    logic           s_v;

    logic [W-1:0]   sh_nx;
    logic           sh_bit;
    logic [W-1:0]   step_sh;
    logic [W-1:0]   e_y;
    logic           e_c;
    logic           last_step;
    logic           wr_res;
    logic [W-1:0]   fin_y;
    logic           fin_c;
    logic           fin_v;

`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]   mc_q;     // multiplicand
    logic [W-1:0]   hi_q;     // high half of the running product
    logic [W:0]     mul_sum;
    logic [W-1:0]   hi_nx;
    logic [W-1:0]   lo_nx;
`endif

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign accept      = in_valid && in_ready;
    assign is_shift_in = (opcode == OP_LSL) || (opcode == OP_LSR) || (opcode == OP_ASR);
    // Shift amounts saturate at W: every bit has left the register by then.
    assign k_amt       = (b >= W_AS_B) ? CW'(W) : CW'(b);

`ifdef ALU_SEQ_MUL_EN
    assign is_mul_in = (opcode == OP_MUL);
`else
    assign is_mul_in = 1'b0;
`endif

    // A zero-length shift completes like any single-cycle op.
    assign multi_in = (is_shift_in && (k_amt != '0)) || is_mul_in;

    // ------------------------------------------------------------------
    // Single-cycle result, computed straight from the request inputs
    // ------------------------------------------------------------------
    assign sum_add  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (opcode == OP_ADC) & c_in};
    assign diff_sub = {1'b0, a} - {1'b0, b};

    always_comb begin
        s_y = '0;
        s_c = 1'b0;
        s_v = 1'b0;
        case (opcode)
            OP_ADD, OP_ADC: begin
                s_y = sum_add[W-1:0];
                s_c = sum_add[W];
                s_v = (a[W-1] == b[W-1]) && (sum_add[W-1] != a[W-1]);
            end
            OP_SUB: begin
                s_y = diff_sub[W-1:0];
                s_c = ~diff_sub[W];   // no borrow means a >= b
                s_v = (a[W-1] != b[W-1]) && (diff_sub[W-1] != a[W-1]);
            end
            OP_AND: s_y = a & b;
            OP_OR:  s_y = a | b;
            OP_XOR: s_y = a ^ b;
            OP_NOT: s_y = ~a;
            OP_LSL, OP_LSR, OP_ASR: s_y = a;   // only reached with k == 0
            default: s_y = '0;                 // illegal opcode
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative step
    // ------------------------------------------------------------------
    always_comb begin
        sh_nx  = sh_q;
        sh_bit = 1'b0;
        case (op_q)
            OP_LSL: begin
                sh_nx  = {sh_q[W-2:0], 1'b0};
                sh_bit = sh_q[W-1];
            end
            OP_LSR: begin
                sh_nx  = {1'b0, sh_q[W-1:1]};
                sh_bit = sh_q[0];
            end
            OP_ASR: begin
                sh_nx  = {sh_q[W-1], sh_q[W-1:1]};
                sh_bit = sh_q[0];
            end
            default: begin
                sh_nx  = sh_q;
                sh_bit = 1'b0;
            end
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // Shift-add: conditionally add the multiplicand to the high half, then
    // shift {carry, hi, lo} right one bit. After W steps {hi, lo} = a * b.
    assign mul_sum = {1'b0, hi_q} + (sh_q[0] ? {1'b0, mc_q} : {(W+1){1'b0}});
    assign hi_nx   = mul_sum[W:1];
    assign lo_nx   = {mul_sum[0], sh_q[W-1:1]};

    always_comb begin
        if (op_q == OP_MUL) begin
            step_sh = lo_nx;
            e_y     = lo_nx;
            e_c     = |hi_nx;
        end else begin
            step_sh = sh_nx;
            e_y     = sh_nx;
            e_c     = sh_bit;
        end
    end
`else
    assign step_sh = sh_nx;
    assign e_y     = sh_nx;
    assign e_c     = sh_bit;
`endif

    assign last_step = (state == EXEC) && (cnt_q == CW'(1));

    // The result register is written either on a single-cycle accept or on the
    // final EXEC step; the two never coincide because in_ready is low in EXEC.
    assign wr_res = (accept && !multi_in) || last_step;
    assign fin_y  = last_step ? e_y  : s_y;
    assign fin_c  = last_step ? e_c  : s_c;
    assign fin_v  = last_step ? 1'b0 : s_v;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = multi_in ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nx = multi_in ? EXEC : DONE;
                end else if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
        busy      = (state == EXEC);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= '0;
            c_out <= 1'b0;
            v     <= 1'b0;
            n     <= 1'b0;
            z     <= 1'b0;
            op_q  <= '0;
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_res) begin
                y     <= fin_y;
                c_out <= fin_c;
                v     <= fin_v;
                n     <= fin_y[W-1];
                z     <= (fin_y == '0);
            end
            if (accept) begin
                op_q <= opcode;
                if (is_mul_in) begin
                    sh_q  <= b;
                    cnt_q <= CW'(W);
                end else begin
                    sh_q  <= a;
                    cnt_q <= k_amt;
                end
            end else if (state == EXEC) begin
                sh_q  <= step_sh;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_q <= '0;
            hi_q <= '0;
        end else begin
            if (accept) begin
                mc_q <= a;
                hi_q <= '0;
            end else if (state == EXEC) begin
                hi_q <= hi_nx;
            end
        end
    end
`endif

endmodule
